// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the population-count width helper.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'd0,
    MODE_SHL   = 3'd1,
    MODE_SHR   = 3'd2,
    MODE_ROL   = 3'd3,
    MODE_ROR   = 3'd4,
    MODE_LOAD  = 3'd5,
    MODE_CLEAR = 3'd6,
    MODE_INV   = 3'd7
  } usr_mode_e;

  // Bits needed to hold a count of 0..width inclusive.
  function automatic int unsigned ones_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle between a driver and the universal shift register.
interface univ_shift_reg_if
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) ();

  localparam int unsigned OW = ones_w(WIDTH);

  logic             EN;
  logic [2:0]       MODE;
  logic [WIDTH-1:0] D;
  logic             SIL;
  logic             SIR;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] nQ;
  logic             SOL;
  logic             SOR;
  logic [OW-1:0]    ONES;
  logic             ZERO;

  modport master (
    output EN, MODE, D, SIL, SIR,
    input  Q, nQ, SOL, SOR, ONES, ZERO
  );

  modport slave (
    input  EN, MODE, D, SIL, SIR,
    output Q, nQ, SOL, SOR, ONES, ZERO
  );

endinterface

// File: rtl/usr_popcnt.sv
// Combinational population count of a WIDTH-bit vector.
module usr_popcnt
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]          data_i,
  output logic [ones_w(WIDTH)-1:0]  ones_o
);

  localparam int unsigned OW = ones_w(WIDTH);

  always_comb begin
    ones_o = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      ones_o = ones_o + OW'(data_i[i]);
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: shift, rotate, load, clear and invert with
// serial-out capture, plus complement, popcount and zero flags.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned     WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic             CK,
  input logic             Cr,
  univ_shift_reg_if.slave bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             sol_q, sol_d;
  logic             sor_q, sor_d;
  usr_mode_e        mode;

  assign mode = usr_mode_e'(bus.MODE);

  // Next-state datapath; serial outs move only on their own shift/rotate.
  always_comb begin
    q_d   = q_q;
    sol_d = sol_q;
    sor_d = sor_q;
    if (bus.EN) begin
      case (mode)
        MODE_HOLD: ;
        MODE_SHL: begin
          q_d   = {q_q[WIDTH-2:0], bus.SIL};
          sol_d = q_q[WIDTH-1];
        end
        MODE_SHR: begin
          q_d   = {bus.SIR, q_q[WIDTH-1:1]};
          sor_d = q_q[0];
        end
        MODE_ROL: begin
          q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sol_d = q_q[WIDTH-1];
        end
        MODE_ROR: begin
          q_d   = {q_q[0], q_q[WIDTH-1:1]};
          sor_d = q_q[0];
        end
        MODE_LOAD:  q_d = bus.D;
        MODE_CLEAR: q_d = RST_VAL;
        MODE_INV:   q_d = ~q_q;
        default:    q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (Cr) begin
      q_q   <= RST_VAL;
      sol_q <= 1'b0;
      sor_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      sol_q <= sol_d;
      sor_q <= sor_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.nQ   = ~q_q;
  assign bus.SOL  = sol_q;
  assign bus.SOR  = sor_q;
  assign bus.ZERO = (q_q == '0);

  usr_popcnt #(.WIDTH(WIDTH)) u_popcnt (
    .data_i (q_q),
    .ones_o (bus.ONES)
  );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=8, RST_VAL=0.
module tb_univ_shift_reg;
  import usr_pkg::*;

  logic CK = 1'b0;
  logic Cr = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  univ_shift_reg_if #(.WIDTH(8)) u_if ();

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .CK  (CK),
    .Cr  (Cr),
    .bus (u_if.slave)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs, clock it, sample 1 time unit after the edge.
  task automatic step(input logic en, input usr_mode_e m, input logic [7:0] d,
                      input logic sil, input logic sir);
    u_if.EN   = en;
    u_if.MODE = m;
    u_if.D    = d;
    u_if.SIL  = sil;
    u_if.SIR  = sir;
    @(posedge CK);
    #1;
  endtask

  initial begin
    logic [7:0] exp_q;
    logic [7:0] sol_seq;
    u_if.EN = 1'b0; u_if.MODE = 3'd0; u_if.D = '0; u_if.SIL = 1'b0; u_if.SIR = 1'b0;

    // Reset, with a non-trivial mode pending
    Cr = 1'b1;
    step(1'b1, MODE_INV, 8'h00, 1'b1, 1'b1);
    chk("rst_q", 64'(u_if.Q), 64'h00);
    chk("rst_nq", 64'(u_if.nQ), 64'hFF);
    chk("rst_sol", 64'(u_if.SOL), 64'h0);
    chk("rst_sor", 64'(u_if.SOR), 64'h0);
    chk("rst_ones", 64'(u_if.ONES), 64'd0);
    chk("rst_zero", 64'(u_if.ZERO), 64'h1);
    Cr = 1'b0;

    // Load A5
    step(1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0);
    chk("load_q", 64'(u_if.Q), 64'hA5);
    chk("load_nq", 64'(u_if.nQ), 64'h5A);
    chk("load_ones", 64'(u_if.ONES), 64'd4);
    chk("load_zero", 64'(u_if.ZERO), 64'h0);

    // Shift left then right through 81
    step(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
    step(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
    chk("shl_q", 64'(u_if.Q), 64'h02);
    chk("shl_sol", 64'(u_if.SOL), 64'h1);
    step(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1);
    chk("shr_q", 64'(u_if.Q), 64'h81);
    chk("shr_sor", 64'(u_if.SOR), 64'h0);
    chk("shr_sol_hold", 64'(u_if.SOL), 64'h1);

    // Rotate left 8 times
    exp_q   = 8'h81;
    sol_seq = 8'b1000_0001;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, MODE_ROL, 8'h00, 1'b1, 1'b1);
      exp_q = {exp_q[6:0], exp_q[7]};
      chk($sformatf("rol_q%0d", i), 64'(u_if.Q), 64'(exp_q));
      chk($sformatf("rol_sol%0d", i), 64'(u_if.SOL), 64'(sol_seq[7-i]));
    end
    chk("rol_final", 64'(u_if.Q), 64'h81);

    // Rotate right once
    step(1'b1, MODE_ROR, 8'h00, 1'b0, 1'b0);
    chk("ror_q", 64'(u_if.Q), 64'hC0);
    chk("ror_sor", 64'(u_if.SOR), 64'h1);

    // Enable low blocks CLEAR; full register shows ONES=8
    step(1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
    chk("ff_ones", 64'(u_if.ONES), 64'd8);
    chk("load_sor_hold", 64'(u_if.SOR), 64'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, MODE_CLEAR, 8'h00, 1'b0, 1'b0);
      chk($sformatf("en0_q%0d", i), 64'(u_if.Q), 64'hFF);
    end
    step(1'b1, MODE_CLEAR, 8'h00, 1'b0, 1'b0);
    chk("clr_q", 64'(u_if.Q), 64'h00);
    chk("clr_zero", 64'(u_if.ZERO), 64'h1);
    chk("clr_ones", 64'(u_if.ONES), 64'd0);

    // Reset wins over LOAD; serial outs cleared
    step(1'b1, MODE_LOAD, 8'h55, 1'b0, 1'b0);
    Cr = 1'b1;
    step(1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0);
    Cr = 1'b0;
    chk("prio_q", 64'(u_if.Q), 64'h00);
    chk("prio_sol", 64'(u_if.SOL), 64'h0);
    chk("prio_sor", 64'(u_if.SOR), 64'h0);

    // Cr pulse between edges is ignored
    step(1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0);
    u_if.MODE = 3'(MODE_HOLD);
    #3 Cr = 1'b1;
    #2 Cr = 1'b0;
    @(posedge CK);
    #1;
    chk("glitch_q", 64'(u_if.Q), 64'h3C);

    // Reset mid-shift leaves nothing behind
    step(1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
    step(1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
    Cr = 1'b1;
    step(1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
    Cr = 1'b0;
    step(1'b1, MODE_HOLD, 8'h00, 1'b1, 1'b0);
    chk("midrst_q", 64'(u_if.Q), 64'h00);
    chk("midrst_sol", 64'(u_if.SOL), 64'h0);

    // Invert twice
    step(1'b1, MODE_LOAD, 8'h0F, 1'b0, 1'b0);
    chk("inv0_ones", 64'(u_if.ONES), 64'd4);
    step(1'b1, MODE_INV, 8'h00, 1'b0, 1'b0);
    chk("inv1_q", 64'(u_if.Q), 64'hF0);
    chk("inv1_ones", 64'(u_if.ONES), 64'd4);
    step(1'b1, MODE_INV, 8'h00, 1'b0, 1'b0);
    chk("inv2_q", 64'(u_if.Q), 64'h0F);
    chk("inv2_ones", 64'(u_if.ONES), 64'd4);
    chk("inv2_nq", 64'(u_if.nQ), 64'hF0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
